// File: rtl/hpdmc_dqio_if.sv
// hpdmc_dqio_if: command/data bundle between the HPDMC datapath/scheduler
// and the DQ bank.
//   cfg_rl        read latency in cycles (0..1 behave as 2)
//   wr_start      single-cycle write burst request
//   wr_data       write beat, consumed at the end of each wr_data_req cycle
//   wr_data_req   beat request from the DQ bank
//   rd_start      single-cycle read burst request
//   rd_data       captured read beat, held while rd_valid=0
//   rd_valid      rd_data carries a fresh beat this cycle
//   busy          burst in progress, commands are dropped
//   err_collision one-cycle pulse when a command was dropped
// master = scheduler side, slave = DQ bank side.
interface hpdmc_dqio_if #(
   parameter int DQ_WIDTH = 32
);
   logic [3:0]          cfg_rl;
   logic                wr_start;
   logic [DQ_WIDTH-1:0] wr_data;
   logic                wr_data_req;
   logic                rd_start;
   logic [DQ_WIDTH-1:0] rd_data;
   logic                rd_valid;
   logic                busy;
   logic                err_collision;

   modport master (
      output cfg_rl, wr_start, wr_data, rd_start,
      input  wr_data_req, rd_data, rd_valid, busy, err_collision
   );

   modport slave (
      input  cfg_rl, wr_start, wr_data, rd_start,
      output wr_data_req, rd_data, rd_valid, busy, err_collision
   );
endinterface

// File: rtl/hpdmc_dqio.sv
// hpdmc_dqio: DQ pin bank for the HPDMC data path. One tristate buffer per
// bit plus the write preamble/burst/postamble and read-capture sequencing.
// Ports:
//   sys_clk    system clock, rising edge
//   sys_rst_n  asynchronous active-low reset; releases dq immediately
//   bus        hpdmc_dqio_if.slave command/data bundle
//   dq         memory DQ pins
// Each bit has its own T flop, output flop and input capture flop so that
// all three can be packed into the pad cell.
module hpdmc_dqio #(
   parameter int DQ_WIDTH = 32,
   parameter int BURST    = 4
) (
   input  logic                sys_clk,
   input  logic                sys_rst_n,
   hpdmc_dqio_if.slave         bus,
   inout  wire  [DQ_WIDTH-1:0] dq
);
   localparam int CW = $clog2(BURST) + 1;
   localparam logic [CW-1:0] REQ_END   = CW'(BURST - 2);
   localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);
   localparam logic [CW-1:0] RD_END    = CW'(BURST);

   typedef enum logic [2:0] {IDLE, WPRE, WBURST, WPOST, RWAIT, RBURST} state_t;

   state_t              state_reg;
   logic [CW-1:0]       beat_reg;
   logic [3:0]          lat_reg;
   logic [DQ_WIDTH-1:0] t_reg;
   logic [DQ_WIDTH-1:0] o_reg;
   logic [DQ_WIDTH-1:0] i_reg;
   logic                req_reg;
   logic                valid_reg;
   logic                busy_reg;
   logic                err_reg;
   logic [3:0]          rl_eff;
   wire  [DQ_WIDTH-1:0] dq_in;

   // Latencies below 2 cannot be honoured: the T/O flops need a cycle.
   assign rl_eff = (bus.cfg_rl < 4'd2) ? 4'd2 : bus.cfg_rl;

   genvar gi;
   generate
      for (gi = 0; gi < DQ_WIDTH; gi++) begin : g_iobuf
         assign dq[gi]    = t_reg[gi] ? 1'bz : o_reg[gi];
         assign dq_in[gi] = dq[gi];
      end
   endgenerate

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_reg <= IDLE;
         beat_reg  <= '0;
         lat_reg   <= '0;
         t_reg     <= '1;
         o_reg     <= '0;
         i_reg     <= '0;
         req_reg   <= 1'b0;
         valid_reg <= 1'b0;
         busy_reg  <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         err_reg   <= 1'b0;
         valid_reg <= 1'b0;
         // Beat k is sampled at the end of its request cycle and appears
         // on the pins one cycle later.
         if (req_reg)
            o_reg <= bus.wr_data;
         case (state_reg)
            IDLE: begin
               beat_reg <= '0;
               if (bus.wr_start) begin
                  // Write wins a simultaneous request; the read is dropped.
                  state_reg <= WPRE;
                  t_reg     <= '0;
                  o_reg     <= '0;
                  req_reg   <= 1'b1;
                  busy_reg  <= 1'b1;
                  err_reg   <= bus.rd_start;
               end else if (bus.rd_start) begin
                  state_reg <= RWAIT;
                  lat_reg   <= rl_eff - 4'd1;
                  busy_reg  <= 1'b1;
               end
            end
            WPRE: begin
               state_reg <= WBURST;
            end
            WBURST: begin
               beat_reg <= beat_reg + CW'(1);
               // Requests run one cycle ahead of the driven beat.
               if (beat_reg == REQ_END)
                  req_reg <= 1'b0;
               if (beat_reg == LAST_BEAT)
                  state_reg <= WPOST;
            end
            WPOST: begin
               state_reg <= IDLE;
               t_reg     <= '1;
               busy_reg  <= 1'b0;
            end
            RWAIT: begin
               lat_reg <= lat_reg - 4'd1;
               if (lat_reg == 4'd1) begin
                  state_reg <= RBURST;
                  beat_reg  <= '0;
               end
            end
            RBURST: begin
               // BURST capture cycles plus one cycle to present the last beat.
               beat_reg <= beat_reg + CW'(1);
               if (beat_reg != RD_END) begin
                  i_reg     <= dq_in;
                  valid_reg <= 1'b1;
               end else begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
         if (state_reg != IDLE && (bus.wr_start || bus.rd_start))
            err_reg <= 1'b1;
      end
   end

   assign bus.wr_data_req   = req_reg;
   assign bus.rd_data       = i_reg;
   assign bus.rd_valid      = valid_reg;
   assign bus.busy          = busy_reg;
   assign bus.err_collision = err_reg;
endmodule

// File: tb/tb_hpdmc_dqio.sv
// tb_hpdmc_dqio: directed bench for hpdmc_dqio. Table of per-cycle vectors
// for the 32-bit/BURST=4 instance, then hand-written sequences for reset
// during a write and a 16-bit/BURST=8 back-to-back write/read.
module tb_hpdmc_dqio;
   localparam logic [31:0] PROBE = 32'hA5A5A5A5;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   hpdmc_dqio_if #(.DQ_WIDTH(32)) bus1 ();
   hpdmc_dqio_if #(.DQ_WIDTH(16)) bus2 ();

   wire  [31:0] dq1;
   wire  [15:0] dq2;
   logic        mem1_oe;
   logic [31:0] mem1_drv;
   logic        mem2_oe;
   logic [15:0] mem2_drv;
   assign dq1 = mem1_oe ? mem1_drv : 'z;
   assign dq2 = mem2_oe ? mem2_drv : 'z;

   hpdmc_dqio #(.DQ_WIDTH(32), .BURST(4)) dut1 (
      .sys_clk(clk), .sys_rst_n(rst_n), .bus(bus1), .dq(dq1));
   hpdmc_dqio #(.DQ_WIDTH(16), .BURST(8)) dut2 (
      .sys_clk(clk), .sys_rst_n(rst_n), .bus(bus2), .dq(dq2));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        wr_start;
      logic        rd_start;
      logic [3:0]  cfg_rl;
      logic [31:0] wr_data;
      logic        mem_oe;
      logic [31:0] mem_drv;
      logic        exp_req;
      logic        exp_busy;
      logic        exp_valid;
      logic        exp_err;
      logic [31:0] exp_rd;
      logic        chk_dq;
      logic [31:0] exp_dq;
   } vec_t;

   vec_t        vq[$];
   logic [31:0] model_rd;

   function automatic vec_t blank();
      vec_t v;
      v.wr_start = 1'b0; v.rd_start = 1'b0; v.cfg_rl = 4'd15; v.wr_data = 32'hFFFF0000;
      v.mem_oe = 1'b0; v.mem_drv = 32'h0; v.exp_req = 1'b0; v.exp_busy = 1'b0;
      v.exp_valid = 1'b0; v.exp_err = 1'b0; v.exp_rd = model_rd;
      v.chk_dq = 1'b0; v.exp_dq = 32'h0;
      return v;
   endfunction

   // Idle cycles: memory drives a probe, which must appear unaltered.
   task automatic add_idle(input int n);
      vec_t v;
      for (int i = 0; i < n; i++) begin
         v = blank();
         v.mem_oe = 1'b1; v.mem_drv = PROBE; v.chk_dq = 1'b1; v.exp_dq = PROBE;
         vq.push_back(v);
      end
   endtask

   task automatic add_write(input logic [31:0] b0, input logic [31:0] b1,
                            input logic [31:0] b2, input logic [31:0] b3, input bit collide);
      logic [31:0] d[4];
      vec_t v[8];
      d[0] = b0; d[1] = b1; d[2] = b2; d[3] = b3;
      for (int i = 0; i < 8; i++) v[i] = blank();
      v[0].wr_start = 1'b1;
      v[0].rd_start = collide;
      for (int i = 1; i <= 6; i++) v[i].exp_busy = 1'b1;
      for (int k = 0; k < 4; k++) begin
         v[1+k].wr_data = d[k];
         v[1+k].exp_req = 1'b1;
         v[2+k].chk_dq  = 1'b1;
         v[2+k].exp_dq  = d[k];
      end
      v[1].chk_dq = 1'b1; v[1].exp_dq = 32'h0;
      v[6].chk_dq = 1'b1; v[6].exp_dq = d[3];
      v[7].mem_oe = 1'b1; v[7].mem_drv = PROBE; v[7].chk_dq = 1'b1; v[7].exp_dq = PROBE;
      if (collide) begin
         v[1].exp_err  = 1'b1;
         v[3].rd_start = 1'b1;
         v[4].exp_err  = 1'b1;
      end
      for (int i = 0; i < 8; i++) vq.push_back(v[i]);
   endtask

   // Read with effective latency rl; junk on the pins just outside the window.
   task automatic add_read(input logic [3:0] cfg, input int rl, input logic [31:0] base);
      vec_t v;
      for (int i = 0; i < rl + 6; i++) begin
         v = blank();
         if (i == 0) begin
            v.rd_start = 1'b1;
            v.cfg_rl   = cfg;
         end
         v.exp_busy = (i >= 1 && i <= rl + 4);
         if (i >= rl && i <= rl + 3) begin
            v.mem_oe = 1'b1; v.mem_drv = base + 32'(i - rl);
         end else if (i == rl - 1) begin
            v.mem_oe = 1'b1; v.mem_drv = 32'hDEADBEEF;
         end else if (i == rl + 4) begin
            v.mem_oe = 1'b1; v.mem_drv = 32'hBADBAD00;
         end
         v.chk_dq = v.mem_oe;
         v.exp_dq = v.mem_drv;
         if (i >= rl + 1 && i <= rl + 4) begin
            v.exp_valid = 1'b1;
            model_rd = base + 32'(i - rl - 1);
         end
         v.exp_rd = model_rd;
         vq.push_back(v);
      end
   endtask

   initial begin
      logic [15:0] beat16;
      logic        e_req, e_busy, e_valid;
      logic [15:0] m2_rd;
      logic [31:0] m1_rd;

      rst_n = 1'b0;
      bus1.cfg_rl = 4'd0; bus1.wr_start = 1'b0; bus1.wr_data = '0; bus1.rd_start = 1'b0;
      bus2.cfg_rl = 4'd0; bus2.wr_start = 1'b0; bus2.wr_data = '0; bus2.rd_start = 1'b0;
      mem1_oe = 1'b0; mem1_drv = '0; mem2_oe = 1'b0; mem2_drv = '0;
      model_rd = '0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 64'(bus1.busy), 64'd0);
      chk("rst_valid", 64'(bus1.rd_valid), 64'd0);
      chk("rst_req", 64'(bus1.wr_data_req), 64'd0);
      chk("rst_rd_data", 64'(bus1.rd_data), 64'd0);
      chk("rst_err", 64'(bus1.err_collision), 64'd0);
      mem1_oe = 1'b1; mem1_drv = PROBE;
      #1;
      chk("rst_dq_released", 64'(dq1), 64'(PROBE));
      mem1_oe = 1'b0;
      rst_n = 1'b1;
      $display("reset: checked");

      // Table-driven main sequence
      add_idle(2);
      add_write(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 1'b0);
      add_idle(2);
      add_read(4'd5, 5, 32'h000000A0);
      add_idle(1);
      add_read(4'd0, 2, 32'h000000B0);
      add_idle(1);
      add_read(4'd1, 2, 32'h000000D0);
      add_idle(1);
      add_write(32'hC1C1C1C1, 32'hC2C2C2C2, 32'hC3C3C3C3, 32'hC4C4C4C4, 1'b1);
      add_idle(2);

      for (int i = 0; i < vq.size(); i++) begin
         @(posedge clk);
         #1;
         bus1.wr_start = vq[i].wr_start;
         bus1.rd_start = vq[i].rd_start;
         bus1.cfg_rl   = vq[i].cfg_rl;
         bus1.wr_data  = vq[i].wr_data;
         mem1_oe       = vq[i].mem_oe;
         mem1_drv      = vq[i].mem_drv;
         @(negedge clk);
         chk($sformatf("v%0d_req", i), 64'(bus1.wr_data_req), 64'(vq[i].exp_req));
         chk($sformatf("v%0d_busy", i), 64'(bus1.busy), 64'(vq[i].exp_busy));
         chk($sformatf("v%0d_valid", i), 64'(bus1.rd_valid), 64'(vq[i].exp_valid));
         chk($sformatf("v%0d_err", i), 64'(bus1.err_collision), 64'(vq[i].exp_err));
         chk($sformatf("v%0d_rd_data", i), 64'(bus1.rd_data), 64'(vq[i].exp_rd));
         if (vq[i].chk_dq)
            chk($sformatf("v%0d_dq", i), 64'(dq1), 64'(vq[i].exp_dq));
         $display("vec %0d: req=%b busy=%b valid=%b err=%b rd=%h dq=%h", i, bus1.wr_data_req,
                  bus1.busy, bus1.rd_valid, bus1.err_collision, bus1.rd_data, dq1);
      end
      bus1.wr_start = 1'b0; bus1.rd_start = 1'b0; mem1_oe = 1'b0;

      // Reset during beat 2 of a write
      @(posedge clk); #1 bus1.wr_start = 1'b1;
      @(posedge clk); #1 bus1.wr_start = 1'b0; bus1.wr_data = 32'h10101010;
      @(posedge clk); #1 bus1.wr_data = 32'h20202020;
      @(posedge clk); #1 bus1.wr_data = 32'h30303030;
      @(negedge clk);
      chk("mr_beat1", 64'(dq1), 64'h20202020);
      @(posedge clk); #1;
      chk("mr_beat2", 64'(dq1), 64'h30303030);
      rst_n = 1'b0; mem1_oe = 1'b1; mem1_drv = PROBE;
      #1;
      chk("mr_dq_released", 64'(dq1), 64'(PROBE));
      chk("mr_busy", 64'(bus1.busy), 64'd0);
      chk("mr_req", 64'(bus1.wr_data_req), 64'd0);
      mem1_oe = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      $display("reset mid-write: checked");
      m1_rd = '0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         bus1.rd_start = (c == 0);
         bus1.cfg_rl   = (c == 0) ? 4'd3 : 4'd15;
         mem1_oe       = (c >= 3 && c <= 6);
         mem1_drv      = 32'hE0 + 32'(c - 3);
         @(negedge clk);
         e_valid = (c >= 4 && c <= 7);
         e_busy  = (c >= 1 && c <= 7);
         if (e_valid) m1_rd = 32'hE0 + 32'(c - 4);
         chk($sformatf("pr%0d_valid", c), 64'(bus1.rd_valid), 64'(e_valid));
         chk($sformatf("pr%0d_busy", c), 64'(bus1.busy), 64'(e_busy));
         chk($sformatf("pr%0d_rd_data", c), 64'(bus1.rd_data), 64'(m1_rd));
         chk($sformatf("pr%0d_err", c), 64'(bus1.err_collision), 64'd0);
      end
      bus1.rd_start = 1'b0; mem1_oe = 1'b0;
      $display("read after reset: checked");

      // 16-bit, BURST=8: write then read at the earliest accept cycle
      m2_rd = '0;
      for (int c = 0; c < 24; c++) begin
         @(posedge clk); #1;
         bus2.wr_start = (c == 0);
         bus2.wr_data  = (c >= 1 && c <= 8) ? 16'h1000 + 16'(c - 1) * 16'h0111 : 16'hFFFF;
         bus2.rd_start = (c == 11);
         bus2.cfg_rl   = (c == 11) ? 4'd2 : 4'd15;
         mem2_oe       = (c == 11) || (c >= 13 && c <= 21);
         mem2_drv      = (c >= 13 && c <= 20) ? 16'hB000 + 16'(c - 13) : 16'h5A5A;
         @(negedge clk);
         e_req   = (c >= 1 && c <= 8);
         e_busy  = (c >= 1 && c <= 10) || (c >= 12 && c <= 21);
         e_valid = (c >= 14 && c <= 21);
         if (e_valid) m2_rd = 16'hB000 + 16'(c - 14);
         chk($sformatf("sw%0d_req", c), 64'(bus2.wr_data_req), 64'(e_req));
         chk($sformatf("sw%0d_busy", c), 64'(bus2.busy), 64'(e_busy));
         chk($sformatf("sw%0d_valid", c), 64'(bus2.rd_valid), 64'(e_valid));
         chk($sformatf("sw%0d_rd_data", c), 64'(bus2.rd_data), 64'(m2_rd));
         chk($sformatf("sw%0d_err", c), 64'(bus2.err_collision), 64'd0);
         if (c == 1)
            chk("sw1_dq_pre", 64'(dq2), 64'd0);
         else if (c >= 2 && c <= 10) begin
            beat16 = 16'h1000 + 16'((c >= 10 ? 9 : c) - 2) * 16'h0111;
            chk($sformatf("sw%0d_dq", c), 64'(dq2), 64'(beat16));
         end else if (mem2_oe)
            chk($sformatf("sw%0d_dq_mem", c), 64'(dq2), 64'(mem2_drv));
      end
      bus2.wr_start = 1'b0; bus2.rd_start = 1'b0; mem2_oe = 1'b0;
      $display("sweep 16x8: checked");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/hpdmc_dqio.md
Name: hpdmc_dqio

Overview:
- Parametrised DQ bank for the HPDMC data path: instantiates one IOBUF per data bit and adds the sequencing that a bare buffer array lacks.
- Sequencing covers registered output-enable control, write preamble/burst/postamble, and read capture at a programmable read latency.
- Sits between the HPDMC datapath/scheduler and the memory DQ pins; owns the bus tristate state.

Parameters:
- DQ_WIDTH, 32, data bus width in bits; multiple of 8, range 8..64.
- BURST, 4, beats per read/write burst; power of 2, range 2..8.

Ports:
- sys_clk  input  1  system clock; all logic rising-edge.
- sys_rst_n  input  1  asynchronous, active-low reset.
- cfg_rl  input  4  read latency in cycles; sampled on read accept; values 0..1 are treated as 2.
- wr_start  input  1  write burst request; single-cycle pulse.
- wr_data  input  DQ_WIDTH  write beat; sampled on cycles where wr_data_req=1.
- wr_data_req  output  1  beat request; wr_data is consumed at the end of this cycle.
- rd_start  input  1  read burst request; single-cycle pulse.
- rd_data  output  DQ_WIDTH  captured read beat.
- rd_valid  output  1  rd_data holds a valid beat this cycle.
- busy  output  1  a burst is in progress; commands are not accepted.
- err_collision  output  1  one-cycle pulse when a command is dropped.
- dq  inout  DQ_WIDTH  memory DQ pins, through the internal IOBUFs.

Behaviour:
- Reset (async, sys_rst_n=0):
  - state=IDLE, all T=1 (dq released), pad output register=0.
  - wr_data_req=0, rd_valid=0, rd_data=0, busy=0, err_collision=0.
  - Reset asserted mid-burst aborts the burst; dq is released immediately, not at the next edge.
- States: IDLE, WPRE, WBURST, WPOST, RWAIT, RBURST.
- Tristate: one T flop per bit, all loaded with the same value. Each bit has a registered output flop and a registered input capture flop, so all three can pack into IOBs.
- Command accept: only in IDLE. Let t0 be the accept cycle.
  - wr_start and rd_start in the same IDLE cycle: the write is accepted, the read is dropped, err_collision pulses at t0+1.
  - Any start while busy=1: the command is dropped, err_collision pulses the next cycle, and the current burst is unaffected.
- Write timeline:
  - t0+1 (WPRE): T=0, dq driven to 0, wr_data_req=1.
  - wr_data_req stays high for cycles t0+1..t0+BURST, exactly BURST cycles.
  - Beat k, sampled at the end of cycle t0+1+k, is driven on dq during cycle t0+2+k (WBURST; k=0..BURST-1).
  - t0+2+BURST (WPOST): T=0, dq holds the last beat.
  - t0+3+BURST: T=1, state=IDLE.
  - busy=1 during t0+1..t0+2+BURST. The next command is accepted at t0+3+BURST at the earliest.
- Read timeline:
  - RL = max(cfg_rl, 2), latched at t0; later cfg_rl changes have no effect on the running burst.
  - RWAIT counts down RL-1 cycles.
  - Beat k is present on dq in cycle t0+RL+k and is captured by the input flop at the end of that cycle.
  - rd_data = beat k with rd_valid=1 in cycle t0+RL+1+k, for k=0..BURST-1. The BURST valid cycles are contiguous.
  - busy=1 during t0+1..t0+RL+BURST. IDLE at t0+RL+BURST+1.
  - rd_data holds its last value while rd_valid=0.
  - T=1 throughout the read.
- Back-to-back: write-to-read gives at least one released cycle (WPOST then IDLE) before the earliest memory drive at RL>=2, so there is no bus contention.
- Widths: beat counter is clog2(BURST)+1 bits; latency counter is 4 bits with no wrap (RL<=15).

Test Plan:
- Reset check: hold sys_rst_n=0 with DQ_WIDTH=32, then release. Required: dq=Z on all 32 bits, busy=0, rd_valid=0, wr_data_req=0.
- Write, BURST=4: wr_start at t0 with wr_data supplying 0x11111111, 0x22222222, 0x33333333, 0x44444444 on each request.
  - wr_data_req high t0+1..t0+4.
  - dq=0 at t0+1, then the four words at t0+2..t0+5.
  - Last word held at t0+6; dq=Z at t0+7.
- Read, cfg_rl=5: rd_start at t0, memory model drives 0xA0..0xA3 (zero-extended) at t0+5..t0+8.
  - rd_valid high exactly t0+6..t0+9 with those values in order.
  - busy falls at t0+10.
  - Repeat with cfg_rl=0: data appears as for RL=2.
- Collisions:
  - wr_start and rd_start together in IDLE: the write burst runs and err_collision=1 at t0+1.
  - rd_start at t0+3 during that write: dropped, err_collision=1 at t0+4, write data unchanged.
- Reset mid-write: assert sys_rst_n=0 during beat 2. Required: dq=Z in the same cycle, state IDLE after release, and a following read completes normally.
- Parameter sweep DQ_WIDTH=16, BURST=8: write then read back-to-back. Required: 8 beats each way, exact timing per the formulas above, and no cycle where dq is driven by both sides.
